// File: rtl/tspi_pkg.sv
// ============================================================================
// tspi_pkg : shared TSPI types and constants
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package tspi_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        TX         = 3'd1,
        WAIT_START = 3'd2,
        RX         = 3'd3,
        RESP       = 3'd4
    } tspi_shift_state_e;

    localparam logic TSPI_IDLE_LEVEL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/tspi_edge_detect.sv
// ============================================================================
// tspi_edge_detect : rising-edge detector for a level already in clk_i domain
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module tspi_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic rise_o
);

    logic level_d;
    logic level_q;

    always_comb level_d = level_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign rise_o = level_i & ~level_q;

endmodule

`default_nettype wire

// File: rtl/tspi_shift_engine.sv
// ============================================================================
// tspi_shift_engine : multi-lane TSPI command shifter with start-bit hunt and
//                     runtime-length response capture
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module tspi_shift_engine
    import tspi_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned NumLanes     = 1,
    parameter int unsigned TimeoutTicks = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         tspi_clk_i,
    input  logic                         abort_i,
    input  logic                         tx_valid_i,
    output logic                         tx_ready_o,
    input  logic [DataWidth-1:0]         tx_data_i,
    input  logic [$clog2(DataWidth)-1:0] tx_len_i,
    input  logic                         rx_expect_i,
    input  logic [$clog2(DataWidth)-1:0] rx_len_i,
    output logic [NumLanes-1:0]          mosi_o,
    input  logic [NumLanes-1:0]          miso_i,
    output logic                         start_bit_o,
    output logic                         timeout_o,
    output logic                         rx_valid_o,
    input  logic                         rx_ready_i,
    output logic [DataWidth-1:0]         rx_data_o,
    output logic                         busy_o
);

    localparam int unsigned LenW      = $clog2(DataWidth);
    localparam int unsigned CntW      = $clog2(DataWidth + 1);
    localparam int unsigned TmoW      = $clog2(TimeoutTicks + 1);
    localparam int unsigned LaneShift = $clog2(NumLanes);

    tspi_shift_state_e     state_d, state_q;
    logic [DataWidth-1:0]  sreg_d, sreg_q;
    logic [CntW-1:0]       cnt_d, cnt_q;
    logic [TmoW-1:0]       tmo_d, tmo_q;
    logic                  rx_expect_d, rx_expect_q;
    logic [LenW-1:0]       rx_len_d, rx_len_q;

    logic                  tick;
    logic [LenW-1:0]       tx_align;
    logic [DataWidth-1:0]  tx_fill;
    logic [DataWidth-1:0]  lane_ones;
    logic [DataWidth-1:0]  rx_mask;

    tspi_edge_detect u_tick (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .level_i (tspi_clk_i),
        .rise_o  (tick)
    );

    // Ones below the left-aligned command make a short final lane group idle high.
    assign tx_align  = LenW'(DataWidth - 1) - tx_len_i;
    assign tx_fill   = ~({DataWidth{1'b1}} << tx_align);
    assign lane_ones = DataWidth'({NumLanes{1'b1}});
    assign rx_mask   = {DataWidth{1'b1}} >> (LenW'(DataWidth - 1) - rx_len_q);

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        rx_expect_d = rx_expect_q;
        rx_len_d    = rx_len_q;
        start_bit_o = 1'b0;
        timeout_o   = 1'b0;

        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_valid_i) begin
                        sreg_d      = (tx_data_i << tx_align) | tx_fill;
                        cnt_d       = CntW'(tx_len_i >> LaneShift) + CntW'(1);
                        rx_expect_d = rx_expect_i;
                        rx_len_d    = rx_len_i;
                        state_d     = TX;
                    end
                end
                TX: begin
                    if (tick) begin
                        sreg_d = (sreg_q << NumLanes) | lane_ones;
                        cnt_d  = cnt_q - CntW'(1);
                        if (cnt_q == CntW'(1)) begin
                            tmo_d   = TmoW'(TimeoutTicks);
                            state_d = rx_expect_q ? WAIT_START : IDLE;
                        end
                    end
                end
                WAIT_START: begin
                    // Start bit is tested first so it wins over the final timeout tick.
                    if (tick) begin
                        if (!miso_i[0]) begin
                            start_bit_o = 1'b1;
                            sreg_d      = '0;
                            cnt_d       = CntW'(rx_len_q >> LaneShift) + CntW'(1);
                            state_d     = RX;
                        end else if (tmo_q == TmoW'(1)) begin
                            timeout_o = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            tmo_d = tmo_q - TmoW'(1);
                        end
                    end
                end
                RX: begin
                    if (tick) begin
                        sreg_d = (sreg_q << NumLanes) | DataWidth'(miso_i);
                        cnt_d  = cnt_q - CntW'(1);
                        if (cnt_q == CntW'(1)) begin
                            state_d = RESP;
                        end
                    end
                end
                RESP: begin
                    if (rx_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            rx_expect_q <= 1'b0;
            rx_len_q    <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            rx_expect_q <= rx_expect_d;
            rx_len_q    <= rx_len_d;
        end
    end

    assign tx_ready_o = (state_q == IDLE) & ~abort_i;
    assign busy_o     = (state_q != IDLE);
    assign rx_valid_o = (state_q == RESP) & ~abort_i;
    assign rx_data_o  = rx_valid_o ? (sreg_q & rx_mask) : '0;
    assign mosi_o     = (state_q == TX) ? sreg_q[DataWidth-1 -: NumLanes]
                                        : {NumLanes{TSPI_IDLE_LEVEL}};

endmodule

`default_nettype wire

// File: tb/tb_tspi_shift_engine.sv
// ============================================================================
// tb_tspi_shift_engine : directed + random bench for single- and quad-lane engines
// Rev 1.0              : initial release
// ============================================================================
`default_nettype none

module tb_tspi_shift_engine;

    localparam int TT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tspi_clk = 1'b0;
    logic        abort = 1'b0;
    logic        tx_valid = 1'b0;
    logic        rx_expect = 1'b0;
    logic        rx_ready = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] tx_data = '0;
    logic [4:0]  tx_len = '0;
    logic [4:0]  rx_len = '0;
    logic [3:0]  miso = 4'hF;

    int checks = 0;
    int errors = 0;
    int sb_cnt = 0;
    int to_cnt = 0;

    wire        tx_ready1, tx_ready4, sb1, sb4, to1, to4, rv1, rv4, busy1, busy4;
    wire [0:0]  mosi1;
    wire [3:0]  mosi4;
    wire [31:0] rd1, rd4;

    tspi_shift_engine #(.DataWidth(32), .NumLanes(1), .TimeoutTicks(TT)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .tspi_clk_i(tspi_clk), .abort_i(abort),
        .tx_valid_i(tx_valid & ~sel), .tx_ready_o(tx_ready1), .tx_data_i(tx_data),
        .tx_len_i(tx_len), .rx_expect_i(rx_expect), .rx_len_i(rx_len),
        .mosi_o(mosi1), .miso_i(miso[0:0]), .start_bit_o(sb1), .timeout_o(to1),
        .rx_valid_o(rv1), .rx_ready_i(rx_ready & ~sel), .rx_data_o(rd1), .busy_o(busy1)
    );

    tspi_shift_engine #(.DataWidth(32), .NumLanes(4), .TimeoutTicks(TT)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .tspi_clk_i(tspi_clk), .abort_i(abort),
        .tx_valid_i(tx_valid & sel), .tx_ready_o(tx_ready4), .tx_data_i(tx_data),
        .tx_len_i(tx_len), .rx_expect_i(rx_expect), .rx_len_i(rx_len),
        .mosi_o(mosi4), .miso_i(miso), .start_bit_o(sb4), .timeout_o(to4),
        .rx_valid_o(rv4), .rx_ready_i(rx_ready & sel), .rx_data_o(rd4), .busy_o(busy4)
    );

    wire [3:0]  mosi      = sel ? mosi4 : {3'b111, mosi1};
    wire        tx_ready  = sel ? tx_ready4 : tx_ready1;
    wire        start_bit = sel ? sb4 : sb1;
    wire        timeout   = sel ? to4 : to1;
    wire        rx_valid  = sel ? rv4 : rv1;
    wire [31:0] rx_data   = sel ? rd4 : rd1;
    wire        busy      = sel ? busy4 : busy1;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_bit) sb_cnt++;
        if (timeout) to_cnt++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane group k of a command: lane NumLanes-1 carries the earliest bit, missing bits idle high.
    function automatic logic [3:0] tx_group(input logic [31:0] d, input int len, input int L, input int k);
        logic [3:0] r;
        int b;
        for (int j = 0; j < 4; j++) begin
            b = len - k * L - (L - 1 - j);
            if (j >= L || b < 0) r[j] = 1'b1;
            else r[j] = d[b];
        end
        return r;
    endfunction

    task automatic tick_hi();
        tspi_clk = 1'b1;
        @(negedge clk);
    endtask

    task automatic tick_lo();
        @(posedge clk); #1;
        tspi_clk = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_abort();
        abort = 1'b1; tspi_clk = 1'b1; miso = 4'h0;
        @(negedge clk);
        chk("abort_no_start", 32'(start_bit), 0);
        chk("abort_no_timeout", 32'(timeout), 0);
        chk("abort_no_rx_valid", 32'(rx_valid), 0);
        @(posedge clk); #1;
        abort = 1'b0; tspi_clk = 1'b0; miso = 4'hF;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_tx_ready", 32'(tx_ready), 1);
        chk("abort_mosi", 32'(mosi), 32'hF);
        @(posedge clk); #1;
    endtask

    task automatic xfer(input bit s, input logic [31:0] data, input int len, input bit rexp,
                        input int rlen, input int st, input logic [31:0] rword,
                        input int abort_at, input int hold, input bit acc_tick);
        int L;
        int ng;
        int n;
        bit started;
        logic [31:0] r;
        logic [31:0] exp_rx;
        L = s ? 4 : 1;
        n = 0;
        started = 1'b0;
        sel = s;
        tx_data = data; tx_len = 5'(len); rx_expect = rexp; rx_len = 5'(rlen);
        tx_valid = 1'b1; tspi_clk = acc_tick;
        @(negedge clk);
        chk("tx_ready_accept", 32'(tx_ready), 1);
        @(posedge clk); #1;
        tx_valid = 1'b0; tspi_clk = 1'b0;
        tx_data = $urandom; tx_len = 5'($urandom); rx_len = 5'($urandom); rx_expect = 1'($urandom);
        @(posedge clk); #1;

        ng = (len + L) / L;
        for (int k = 0; k < ng; k++) begin
            if (n == abort_at) begin do_abort(); return; end
            tick_hi();
            chk("mosi_tx", 32'(mosi), 32'(tx_group(data, len, L, k)));
            tick_lo();
            n++;
        end
        if (!rexp) begin
            @(negedge clk);
            chk("tx_done_mosi", 32'(mosi), 32'hF);
            chk("tx_done_busy", 32'(busy), 0);
            chk("tx_done_ready", 32'(tx_ready), 1);
            @(posedge clk); #1;
            return;
        end

        for (int t = 1; t <= TT; t++) begin
            if (n == abort_at) begin do_abort(); return; end
            r = $urandom;
            miso = {r[2:0], (t == st) ? 1'b0 : 1'b1};
            tick_hi();
            chk("start_bit", 32'(start_bit), 32'(t == st));
            chk("timeout", 32'(timeout), 32'(t == TT && st > TT));
            tick_lo();
            n++;
            if (t == st) begin started = 1'b1; break; end
        end
        if (!started) begin
            @(negedge clk);
            chk("timeout_busy", 32'(busy), 0);
            chk("timeout_ready", 32'(tx_ready), 1);
            @(posedge clk); #1;
            return;
        end

        ng = (rlen + L) / L;
        for (int g = 0; g < ng; g++) begin
            if (n == abort_at) begin do_abort(); return; end
            miso = 4'((rword >> ((ng - 1 - g) * L)) & ((32'd1 << L) - 1));
            tick_hi();
            chk("mosi_rx", 32'(mosi), 32'hF);
            tick_lo();
            n++;
        end
        exp_rx = (rlen == 31) ? rword : (rword & ((32'd1 << (rlen + 1)) - 1));

        for (int i = 0; i < hold; i++) begin
            tx_valid = 1'b1; tx_data = $urandom; tspi_clk = i[0];
            @(negedge clk);
            chk("hold_rx_valid", 32'(rx_valid), 1);
            chk("hold_rx_data", rx_data, exp_rx);
            chk("hold_tx_ready", 32'(tx_ready), 0);
            @(posedge clk); #1;
        end
        tx_valid = 1'b0; tspi_clk = 1'b0; rx_ready = 1'b1;
        @(negedge clk);
        chk("rx_valid", 32'(rx_valid), 1);
        chk("rx_data", rx_data, exp_rx);
        @(posedge clk); #1;
        rx_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_ready", 32'(tx_ready), 1);
        chk("post_hs_valid", 32'(rx_valid), 0);
        chk("post_hs_data", rx_data, 0);
        chk("post_hs_busy", 32'(busy), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int sb_before;
        int to_before;
        int abort_at;
        repeat (3) @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            @(negedge clk);
            chk("rst_tx_ready", 32'(tx_ready), 1);
            chk("rst_mosi", 32'(mosi), 32'hF);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rx_valid", 32'(rx_valid), 0);
            chk("rst_rx_data", rx_data, 0);
            chk("rst_start_timeout", {30'd0, start_bit, timeout}, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer(0, 32'hA5, 7, 0, 0, 0, 0, -1, 0, 0);
        xfer(1, 32'h1234, 15, 0, 0, 0, 0, -1, 0, 1);
        xfer(1, 32'h1234, 13, 0, 0, 0, 0, -1, 0, 0);

        sb_before = sb_cnt;
        xfer(0, 32'hA5, 7, 1, 11, 3, 32'h0000_0ABC, -1, 10, 0);
        chk("start_bit_once", 32'(sb_cnt - sb_before), 1);

        to_before = to_cnt;
        xfer(0, 32'h5A, 7, 1, 11, 100, 32'h0, -1, 0, 0);
        chk("timeout_once", 32'(to_cnt - to_before), 1);

        sb_before = sb_cnt;
        to_before = to_cnt;
        xfer(0, 32'h3C, 7, 1, 7, 64, 32'h96, -1, 1, 0);
        chk("last_tick_start_only", 32'(sb_cnt - sb_before), 1);
        chk("last_tick_no_timeout", 32'(to_cnt - to_before), 0);

        xfer(0, 32'hA5, 7, 0, 0, 0, 0, 3, 0, 0);
        xfer(0, 32'h3C, 7, 0, 0, 0, 0, -1, 0, 0);
        xfer(1, 32'h1234, 15, 1, 11, 2, 32'hABC, 7, 0, 0);
        xfer(1, 32'hBEEF, 15, 1, 11, 1, 32'h123, -1, 2, 0);

        for (int i = 0; i < 24; i++) begin
            abort_at = ($urandom % 4 == 0) ? int'($urandom_range(0, 20)) : -1;
            xfer(1'($urandom), $urandom, int'($urandom_range(0, 31)), 1'($urandom),
                 int'($urandom_range(0, 31)), int'($urandom_range(1, 70)), $urandom,
                 abort_at, int'($urandom_range(0, 4)), 1'($urandom));
        end

        sel = 1'b0; tx_data = 32'h0; tx_len = 5'd31; rx_expect = 1'b0; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_mosi", 32'(mosi), 32'hE);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_mosi", 32'(mosi), 32'hF);
        chk("async_reset_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 32'hC3, 7, 0, 0, 0, 0, -1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
